// File: rtl/pc_unit_hs_if.sv
// Fetch-side bundle for pc_unit_hs: handshake, redirect controls and return-stack hints.
// master = the PC unit, slave = hazard/redirect logic plus instruction memory.
interface pc_unit_hs_if #(
  parameter int unsigned XLEN = 32
);
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_addr;
  logic [XLEN-1:0] pc_save;
  logic            mpc;
  logic            jalr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] imm_rs;
  logic            flush;
  logic [XLEN-1:0] flush_target;
  logic            halt;
  logic            resume;
  logic            ras_push;
  logic            ras_pop;

  modport master (
    input  fetch_ready, mpc, jalr, imm, imm_rs, flush, flush_target,
           halt, resume, ras_push, ras_pop,
    output fetch_valid, pc_addr, pc_save
  );

  modport slave (
    output fetch_ready, mpc, jalr, imm, imm_rs, flush, flush_target,
           halt, resume, ras_push, ras_pop,
    input  fetch_valid, pc_addr, pc_save
  );
endinterface

// File: rtl/pc_unit_hs.sv
// Fetch program counter with valid/ready issue, halt/resume control and redirect priority.
// Define PC_UNIT_RAS_EN to add a circular return-address stack used by jalr returns.
//
// state  | meaning
// S_BOOT | single idle cycle after reset release, no fetch issued
// S_RUN  | fetch_valid high, PC advances on each accepted fetch
// S_HALT | fetch_valid low, PC frozen until resume or flush
module pc_unit_hs #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter int unsigned      INCR         = 1,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  pc_unit_hs_if.master bus
);

  localparam logic [XLEN-1:0] STEP = XLEN'(INCR);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_seq, pc_rel, jalr_tgt;
  logic            accept;

  assign pc_seq          = pc_q + STEP;
  assign pc_rel          = pc_q + bus.imm;
  assign bus.fetch_valid = (state_q == S_RUN);
  assign bus.pc_addr     = pc_q;
  assign bus.pc_save     = bus.mpc ? pc_seq : pc_rel;
  assign accept          = bus.fetch_valid & bus.fetch_ready;

`ifdef PC_UNIT_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, wr_idx;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ras_hit, do_push, do_pop;

  // ptr_q always addresses the current top; a push that coincides with a pop rewrites it in place
  assign ras_hit  = bus.jalr & bus.ras_pop & (cnt_q != '0);
  assign do_push  = accept & ~bus.flush & bus.ras_push;
  assign do_pop   = accept & ~bus.flush & ras_hit;
  assign wr_idx   = do_pop ? ptr_q : ptr_q + PW'(1);
  assign jalr_tgt = ras_hit ? ras_q[ptr_q] : bus.imm_rs;

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      ptr_d = '0;
      cnt_d = '0;
    end else if (do_push && !do_pop) begin
      ptr_d = ptr_q + PW'(1);
      if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      ptr_d = ptr_q - PW'(1);
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) ras_q[wr_idx] <= pc_seq;
  end
`else
  logic unused_ras;
  assign unused_ras = ^{bus.ras_push, bus.ras_pop, RAS_DEPTH[0]};
  assign jalr_tgt   = bus.imm_rs;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
        if (bus.flush) pc_d = bus.flush_target;
      end
      S_RUN: begin
        if (bus.flush) begin
          pc_d = bus.flush_target;
        end else begin
          if (accept) begin
            if (bus.jalr)     pc_d = jalr_tgt;
            else if (bus.mpc) pc_d = pc_rel;
            else              pc_d = pc_seq;
          end
          if (bus.halt) state_d = S_HALT;
        end
      end
      S_HALT: begin
        if (bus.flush) begin
          pc_d    = bus.flush_target;
          state_d = S_RUN;
        end else if (bus.resume && !bus.halt) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit_hs.sv
// Directed bench for pc_unit_hs: a queue-based reference model checked every cycle,
// plus literal expectations along the stimulus path (RAS cases depend on PC_UNIT_RAS_EN).
module tb_pc_unit_hs;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          DEPTH = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  pc_unit_hs_if #(.XLEN(32)) bus ();

  pc_unit_hs #(.XLEN(32), .RESET_VECTOR(RV), .INCR(1), .RAS_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC value, issue/halt flags and the return stack as a queue (back = top)
  logic [31:0] m_pc   = RV;
  bit          m_boot = 1'b1;
  bit          m_halt = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge reset) begin
    logic [31:0] nxt;
    if (!reset) begin
      m_pc = RV; m_boot = 1'b1; m_halt = 1'b0; m_ras.delete();
    end else if (m_boot) begin
      m_boot = 1'b0;
      if (bus.flush) begin m_pc = bus.flush_target; m_ras.delete(); end
    end else if (bus.flush) begin
      m_pc = bus.flush_target; m_halt = 1'b0; m_ras.delete();
    end else if (m_halt) begin
      if (bus.resume && !bus.halt) m_halt = 1'b0;
    end else begin
      if (bus.fetch_ready) begin
        nxt = m_pc + 32'd1;
        if (bus.jalr) begin
          if (RAS_ON && bus.ras_pop && m_ras.size() > 0) nxt = m_ras.pop_back();
          else nxt = bus.imm_rs;
        end else if (bus.mpc) begin
          nxt = m_pc + bus.imm;
        end
        if (RAS_ON && bus.ras_push) begin
          m_ras.push_back(m_pc + 32'd1);
          if (m_ras.size() > DEPTH) m_ras.delete(0);
        end
        m_pc = nxt;
      end
      if (bus.halt) m_halt = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, (!m_boot && !m_halt)});
    chk("pc_addr", bus.pc_addr, m_pc);
    chk("pc_save", bus.pc_save, bus.mpc ? m_pc + 32'd1 : m_pc + bus.imm);
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    bus.flush = 1'b1; bus.flush_target = tgt;
    cyc();
    bus.flush = 1'b0;
  endtask

  initial begin
    bus.fetch_ready = 1'b1; bus.mpc = 1'b1; bus.jalr = 1'b0;
    bus.imm = '0; bus.imm_rs = '0; bus.flush = 1'b0; bus.flush_target = '0;
    bus.halt = 1'b0; bus.resume = 1'b0; bus.ras_push = 1'b0; bus.ras_pop = 1'b0;
    #1 reset = 1'b0;
    #11;
    chk("rst_pc", bus.pc_addr, 32'h100);
    chk("rst_valid", {31'b0, bus.fetch_valid}, 32'd0);
    chk("rst_save", bus.pc_save, 32'h101);
    bus.mpc = 1'b0;
    reset = 1'b1;
    #1 chk("boot_valid", {31'b0, bus.fetch_valid}, 32'd0);
    cyc();
    chk("run_pc0", bus.pc_addr, 32'h100);
    chk("run_valid", {31'b0, bus.fetch_valid}, 32'd1);
    cyc(); chk("run_pc1", bus.pc_addr, 32'h101);
    cyc(); chk("run_pc2", bus.pc_addr, 32'h102);

    do_flush(32'h10);
    chk("flush_pc", bus.pc_addr, 32'h10);
    bus.imm = 32'd8;
    #1 chk("save_imm", bus.pc_save, 32'h18);
    bus.mpc = 1'b1; bus.imm = 32'hFFFF_FFFC;
    #1 chk("save_incr", bus.pc_save, 32'h11);
    cyc(); bus.mpc = 1'b0;
    chk("mpc_back", bus.pc_addr, 32'h0C);

    bus.fetch_ready = 1'b0; bus.imm_rs = 32'h40; bus.imm = 32'd8;
    for (int i = 0; i < 3; i++) begin
      bus.mpc = i[0]; bus.jalr = ~i[0];
      cyc(); chk("stall_hold", bus.pc_addr, 32'h0C);
    end
    bus.fetch_ready = 1'b1; bus.jalr = 1'b1; bus.mpc = 1'b1;
    cyc(); bus.jalr = 1'b0; bus.mpc = 1'b0;
    chk("jalr_prio", bus.pc_addr, 32'h40);

    do_flush(32'h20);
    bus.halt = 1'b1;
    cyc(); bus.halt = 1'b0;
    chk("halt_adv", bus.pc_addr, 32'h21);
    chk("halt_valid", {31'b0, bus.fetch_valid}, 32'd0);
    cyc(); chk("halt_hold", bus.pc_addr, 32'h21);
    bus.halt = 1'b1; bus.resume = 1'b1;
    cyc(); bus.resume = 1'b0;
    chk("halt_res_both", {31'b0, bus.fetch_valid}, 32'd0);
    do_flush(32'h80); bus.halt = 1'b0;
    chk("halt_flush_pc", bus.pc_addr, 32'h80);
    chk("halt_flush_run", {31'b0, bus.fetch_valid}, 32'd1);
    bus.halt = 1'b1; cyc(); bus.halt = 1'b0;
    bus.resume = 1'b1; cyc(); bus.resume = 1'b0;
    chk("resume_pc", bus.pc_addr, 32'h81);
    chk("resume_valid", {31'b0, bus.fetch_valid}, 32'd1);
    bus.halt = 1'b1; cyc(); bus.halt = 1'b0;
    reset = 1'b0;
    #1 chk("midrst_pc", bus.pc_addr, 32'h100);
    chk("midrst_valid", {31'b0, bus.fetch_valid}, 32'd0);
    reset = 1'b1;
    cyc();
    chk("reboot_pc", bus.pc_addr, 32'h100);

    do_flush(32'hFFFF_FFFF);
    cyc(); chk("wrap", bus.pc_addr, 32'h0);

    bus.imm_rs = 32'h77;
`ifdef PC_UNIT_RAS_EN
    do_flush(32'h10);
    bus.ras_push = 1'b1; cyc(5); bus.ras_push = 1'b0;
    chk("push5_pc", bus.pc_addr, 32'h15);
    bus.jalr = 1'b1; bus.ras_pop = 1'b1;
    cyc(); chk("pop1", bus.pc_addr, 32'h15);
    cyc(); chk("pop2", bus.pc_addr, 32'h14);
    cyc(); chk("pop3", bus.pc_addr, 32'h13);
    cyc(); chk("pop4", bus.pc_addr, 32'h12);
    cyc(); chk("pop_empty", bus.pc_addr, 32'h77);
    bus.jalr = 1'b0; bus.ras_pop = 1'b0;
    do_flush(32'h30);
    bus.ras_push = 1'b1; cyc();
    bus.jalr = 1'b1; bus.ras_pop = 1'b1;
    cyc(); chk("pushpop_tgt", bus.pc_addr, 32'h31);
    bus.ras_push = 1'b0;
    cyc(); chk("pushpop_top", bus.pc_addr, 32'h32);
    cyc(); chk("pushpop_empty", bus.pc_addr, 32'h77);
    bus.jalr = 1'b0; bus.ras_pop = 1'b0;
    bus.ras_push = 1'b1; cyc();
    do_flush(32'h50); bus.ras_push = 1'b0;
    bus.jalr = 1'b1; bus.ras_pop = 1'b1;
    cyc(); chk("flush_clears", bus.pc_addr, 32'h77);
`else
    do_flush(32'h10);
    bus.ras_push = 1'b1; cyc();
    bus.jalr = 1'b1; bus.ras_pop = 1'b1;
    cyc(); chk("noras_jalr", bus.pc_addr, 32'h77);
`endif
    bus.jalr = 1'b0; bus.ras_pop = 1'b0; bus.ras_push = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
